// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
//   state_e     : detector state (IDLE / FILL / SEARCH), 2-bit encoding
//   fill_cnt_w  : width of the fill counter, enough to hold 0..pattern_len
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FILL   = 2'b01,
    SEARCH = 2'b10
  } state_e;

  function automatic int fill_cnt_w(input int pattern_len);
    return $clog2(pattern_len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with sticky saturation flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_inc      : count one event (ignored once the counter is at its maximum)
//   i_clr      : synchronous clear of value and flag; wins over i_inc
//   o_value    : current count
//   o_sat      : sticky, set on the increment that reaches the maximum
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_value,
  output logic             o_sat
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

  logic [WIDTH-1:0] r_value;
  logic             r_sat;

  // Count register and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= ZERO_VAL;
      r_sat   <= 1'b0;
    end else if (i_clr) begin
      r_value <= ZERO_VAL;
      r_sat   <= 1'b0;
    end else if (i_inc && (r_value != MAX_VAL)) begin
      r_value <= r_value + ONE_VAL;
      r_sat   <= (r_value == (MAX_VAL - ONE_VAL));
    end else begin
      r_value <= r_value;
      r_sat   <= r_sat;
    end
  end

  assign o_value = r_value;
  assign o_sat   = r_sat;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with programmable pattern,
// overlap / non-overlap mode and a saturating match counter.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : low forces IDLE (window contents discarded)
//   in_valid     : qualifies in_bit
//   in_bit       : serial data, first received bit ends up as pattern MSB
//   overlap_en   : 1 = keep searching after a hit, 0 = refill after a hit
//   pat_load     : load pat_in as the new pattern, restart the window
//   pat_in       : new pattern
//   cnt_clr      : synchronous clear of match_count / cnt_sat
//   match        : registered one-cycle pulse per hit
//   match_count  : saturating hit count
//   cnt_sat      : sticky, match_count reached its maximum
//   primed       : a full window is held (state SEARCH)
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                     PATTERN_LEN   = 4,
  parameter logic [PATTERN_LEN-1:0] RESET_PATTERN = 4'b1011,
  parameter int                     COUNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   in_valid,
  input  logic                   in_bit,
  input  logic                   overlap_en,
  input  logic                   pat_load,
  input  logic [PATTERN_LEN-1:0] pat_in,
  input  logic                   cnt_clr,
  output logic                   match,
  output logic [COUNT_W-1:0]     match_count,
  output logic                   cnt_sat,
  output logic                   primed
);

  localparam int                FILL_W    = fill_cnt_w(PATTERN_LEN);
  localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PATTERN_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN);
  localparam logic [PATTERN_LEN-2:0] HIST_ZERO = {(PATTERN_LEN-1){1'b0}};

  // The oldest bit of the history is always shifted out before a compare
  // could use it, so only the newest PATTERN_LEN-1 bits are stored.
  state_e                 r_state;
  logic [PATTERN_LEN-1:0] r_pattern;
  logic [PATTERN_LEN-2:0] r_hist;
  logic [FILL_W-1:0]      r_fill;
  logic                   r_match;
  logic                   r_primed;

  state_e                 w_next_state;
  logic [PATTERN_LEN-1:0] w_next_pattern;
  logic [PATTERN_LEN-2:0] w_next_hist;
  logic [FILL_W-1:0]      w_next_fill;
  logic                   w_accept;
  logic                   w_full;
  logic                   w_hit;
  logic [PATTERN_LEN-1:0] w_window;

  // Hit detection: a compare only happens when the accepted bit completes
  // (last FILL bit) or extends (SEARCH) a full window.
  always_comb begin
    w_accept = enable & in_valid & ~pat_load;
    w_window = {r_hist, in_bit};
    w_full   = (r_state == SEARCH) || ((r_state == FILL) && (r_fill == FILL_LAST));
    w_hit    = w_accept && w_full && (w_window == r_pattern);
  end

  // Next-state, history, fill and pattern update.
  always_comb begin
    w_next_state   = r_state;
    w_next_pattern = r_pattern;
    w_next_hist    = r_hist;
    w_next_fill    = r_fill;
    if (pat_load) begin
      w_next_pattern = pat_in;
      w_next_hist    = HIST_ZERO;
      w_next_fill    = FILL_ZERO;
      w_next_state   = enable ? FILL : IDLE;
    end else if (!enable) begin
      w_next_hist  = HIST_ZERO;
      w_next_fill  = FILL_ZERO;
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          // Bits offered during the IDLE->FILL cycle are not consumed.
          w_next_state = FILL;
        end
        FILL: begin
          if (w_accept) begin
            w_next_hist = w_window[PATTERN_LEN-2:0];
            if (r_fill == FILL_LAST) begin
              if (w_hit && !overlap_en) begin
                w_next_fill  = FILL_ZERO;
                w_next_state = FILL;
              end else begin
                w_next_fill  = FILL_FULL;
                w_next_state = SEARCH;
              end
            end else begin
              w_next_fill = r_fill + FILL_ONE;
            end
          end else begin
            w_next_state = FILL;
          end
        end
        SEARCH: begin
          if (w_accept) begin
            w_next_hist = w_window[PATTERN_LEN-2:0];
            if (w_hit && !overlap_en) begin
              w_next_fill  = FILL_ZERO;
              w_next_state = FILL;
            end else begin
              w_next_state = SEARCH;
            end
          end else begin
            w_next_state = SEARCH;
          end
        end
        default: begin
          w_next_hist  = HIST_ZERO;
          w_next_fill  = FILL_ZERO;
          w_next_state = IDLE;
        end
      endcase
    end
  end

  // State, window and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pattern <= RESET_PATTERN;
      r_hist    <= HIST_ZERO;
      r_fill    <= FILL_ZERO;
      r_match   <= 1'b0;
      r_primed  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pattern <= w_next_pattern;
      r_hist    <= w_next_hist;
      r_fill    <= w_next_fill;
      r_match   <= w_hit;
      // Registered from the next state so primed tracks r_state exactly.
      r_primed  <= (w_next_state == SEARCH);
    end
  end

  sat_counter #(
    .WIDTH (COUNT_W)
  ) u_match_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_hit),
    .i_clr   (cnt_clr),
    .o_value (match_count),
    .o_sat   (cnt_sat)
  );

  assign match  = r_match;
  assign primed = r_primed;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst_n;
  // main DUT: defaults (4-bit pattern 1011, 8-bit counter)
  logic       en, vld, bt, ovl, ld, clr;
  logic [3:0] pin;
  logic       m_o, sat_o, pr_o;
  logic [7:0] cnt_o;
  // second DUT: 2-bit pattern 11, 2-bit counter
  logic       en2, vld2, bt2, ovl2, ld2, clr2;
  logic [1:0] pin2;
  logic       m2_o, sat2_o, pr2_o;
  logic [1:0] cnt2_o;

  int checks = 0;
  int errors = 0;

  // reference model state: pattern, idle flag, queue of window bits
  logic [3:0] md_pat;
  bit         md_idle;
  bit         md_q[$];
  int         md_cnt;
  bit         md_sat, md_match, md_primed;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .in_valid(vld), .in_bit(bt),
    .overlap_en(ovl), .pat_load(ld), .pat_in(pin), .cnt_clr(clr),
    .match(m_o), .match_count(cnt_o), .cnt_sat(sat_o), .primed(pr_o));

  seq_detector_param #(.PATTERN_LEN(2), .RESET_PATTERN(2'b11), .COUNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(en2), .in_valid(vld2), .in_bit(bt2),
    .overlap_en(ovl2), .pat_load(ld2), .pat_in(pin2), .cnt_clr(clr2),
    .match(m2_o), .match_count(cnt2_o), .cnt_sat(sat2_o), .primed(pr2_o));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    md_pat = 4'b1011; md_idle = 1'b1; md_q.delete();
    md_cnt = 0; md_sat = 1'b0; md_match = 1'b0; md_primed = 1'b0;
  endtask

  // One clock of the specification's rules, in terms of "bits seen since
  // the window was last restarted".
  task automatic model_step();
    bit hit = 1'b0;
    if (ld) begin
      md_pat = pin; md_q.delete(); md_idle = !en;
    end else if (!en) begin
      md_q.delete(); md_idle = 1'b1;
    end else if (md_idle) begin
      md_idle = 1'b0;
    end else if (vld) begin
      md_q.push_back(bt);
      if (md_q.size() > 4) void'(md_q.pop_front());
      if (md_q.size() == 4) begin
        hit = 1'b1;
        for (int i = 0; i < 4; i++) if (md_q[i] != md_pat[3-i]) hit = 1'b0;
        if (hit && !ovl) md_q.delete();
      end
    end
    if (clr) begin
      md_cnt = 0; md_sat = 1'b0;
    end else if (hit && md_cnt < 255) begin
      md_cnt++;
      if (md_cnt == 255) md_sat = 1'b1;
    end
    md_match  = hit;
    md_primed = !md_idle && (md_q.size() == 4);
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".match"}, 32'(m_o), 32'(md_match));
    chk({tag, ".count"}, 32'(cnt_o), 32'(md_cnt));
    chk({tag, ".sat"}, 32'(sat_o), 32'(md_sat));
    chk({tag, ".primed"}, 32'(pr_o), 32'(md_primed));
  endtask

  task automatic step(input string tag, input logic e, input logic v, input logic b,
                      input logic o, input logic l, input logic [3:0] p, input logic c);
    en = e; vld = v; bt = b; ovl = o; ld = l; pin = p; clr = c;
    @(posedge clk); #1;
    model_step();
    model_check(tag);
  endtask

  task automatic stream(input string tag, input logic [6:0] bits, input int n,
                        input logic o, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(tag, 1'b1, 1'b1, bits[i], o, 1'b0, 4'd0, 1'b0);
      for (int g = 0; g < gap; g++) step(tag, 1'b1, 1'b0, 1'b0, o, 1'b0, 4'd0, 1'b0);
    end
  endtask

  task automatic do_reset();
    en = 1'b0; vld = 1'b1; bt = 1'b1; ovl = 1'b0; ld = 1'b0; pin = 4'd0; clr = 1'b0;
    en2 = 1'b0; vld2 = 1'b0; bt2 = 1'b0; ovl2 = 1'b0; ld2 = 1'b0; pin2 = 2'd0; clr2 = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    model_check("reset");
    rst_n = 1'b1;
  endtask

  task automatic step2(input logic v, input logic b, input logic c);
    en2 = 1'b1; vld2 = v; bt2 = b; ovl2 = 1'b1; clr2 = c;
    @(posedge clk); #1;
  endtask

  initial begin
    // reset held while the stream toggles, then the basic detection
    do_reset();
    step("idle2fill", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    stream("first", 7'b0001011, 4, 1'b1, 0);
    chk("first.match_const", 32'(m_o), 32'd1);
    chk("first.count_const", 32'(cnt_o), 32'd1);
    chk("first.primed_const", 32'(pr_o), 32'd1);

    // overlap: 1011 then 011 completes a second 1011
    stream("ovl", 7'b0000011, 3, 1'b1, 0);
    chk("ovl.count_const", 32'(cnt_o), 32'd2);

    // non-overlap: same stream gives one match
    do_reset();
    step("idle2fill", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    stream("novl", 7'b1011011, 4, 1'b0, 0);
    chk("novl.primed_drop", 32'(pr_o), 32'd0);
    stream("novl", 7'b0000011, 3, 1'b0, 0);
    chk("novl.count_const", 32'(cnt_o), 32'd1);

    // gaps of three invalid cycles between bits
    do_reset();
    step("idle2fill", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    stream("gap", 7'b0001011, 4, 1'b0, 3);

    // pat_load collides with a valid bit: the bit is dropped
    step("load", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1100, 1'b0);
    chk("load.match_const", 32'(m_o), 32'd0);
    stream("pat1100", 7'b0001100, 4, 1'b0, 0);
    chk("pat1100.match_const", 32'(m_o), 32'd1);

    // saturation on the small instance: six 1s against pattern 11
    en = 1'b0;
    step2(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step2(1'b1, 1'b1, 1'b0);
      chk("sat.match", 32'(m2_o), (i == 0) ? 32'd0 : 32'd1);
      chk("sat.count", 32'(cnt2_o), (i < 4) ? 32'(i) : 32'd3);
      chk("sat.flag", 32'(sat2_o), (i >= 3) ? 32'd1 : 32'd0);
    end
    step2(1'b1, 1'b1, 1'b1);
    chk("clr_hit.match", 32'(m2_o), 32'd1);
    chk("clr_hit.count", 32'(cnt2_o), 32'd0);
    chk("clr_hit.sat", 32'(sat2_o), 32'd0);

    // async reset mid-operation, with a different pattern loaded
    do_reset();
    step("idle2fill", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    stream("pre", 7'b1011011, 7, 1'b1, 0);
    chk("pre.count_const", 32'(cnt_o), 32'd2);
    chk("pre.primed_const", 32'(pr_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.match", 32'(m_o), 32'd0);
    chk("arst.count", 32'(cnt_o), 32'd0);
    chk("arst.primed", 32'(pr_o), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle2fill", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step("ld0110", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle2fill", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    stream("repat", 7'b0001011, 4, 1'b0, 0);
    chk("repat.match_const", 32'(m_o), 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 59) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
